// File: rtl/mc8051_instr_sequencer_pkg.sv
// Shared types and constants for the mc8051 instruction sequencer.
// Covers the state encoding, the opcodes the sequencer handles specially, and the widths of the length/cycle fields.
package mc8051_instr_sequencer_pkg;

    // state | meaning: FETCH_OP opcode read, FETCH_OPR1/2 operand reads, EXEC datapath steps
    typedef enum logic [1:0] {
        ST_FETCH_OP   = 2'd0,
        ST_FETCH_OPR1 = 2'd1,
        ST_FETCH_OPR2 = 2'd2,
        ST_EXEC       = 2'd3
    } seq_state_e;

    localparam int LEN_W  = 2;
    localparam int CYC_W  = 3;
    localparam int STEP_W = 2;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LCALL = 8'h12;
    localparam logic [7:0] OP_MUL   = 8'hA4;
    localparam logic [7:0] OP_DIV   = 8'h84;

    // Packs a table entry as {len, cycles}.
    function automatic logic [LEN_W+CYC_W-1:0] info(input logic [LEN_W-1:0] len,
                                                    input logic [CYC_W-1:0] cycles);
        return {len, cycles};
    endfunction

endpackage

// File: rtl/mc8051_instr_len_rom.sv
// Opcode -> {byte length, machine cycles} lookup for the standard 8051 instruction set.
// The table is decoded by opcode column, with the row selecting within a column.
module mc8051_instr_len_rom
    import mc8051_instr_sequencer_pkg::*;
#(
    parameter logic [7:0] ILLEGAL_OP = 8'hA5
) (
    input  logic [7:0]       opcode_i,
    output logic [LEN_W-1:0] len_o,
    output logic [CYC_W-1:0] cycles_o
);

    logic [3:0] hi;
    logic [3:0] lo;
    logic [LEN_W+CYC_W-1:0] info_d;

    assign hi = opcode_i[7:4];
    assign lo = opcode_i[3:0];

    always_comb begin
        info_d = info(2'd1, 3'd1);
        if (opcode_i == ILLEGAL_OP) begin
            info_d = info(2'd1, 3'd1);
        end else if (opcode_i == OP_MUL || opcode_i == OP_DIV) begin
            info_d = info(2'd1, 3'd4);
        end else begin
            case (lo)
                4'h0: begin
                    case (hi)
                        4'h0:                      info_d = info(2'd1, 3'd1);
                        4'h1, 4'h2, 4'h3, 4'h9:    info_d = info(2'd3, 3'd2);
                        4'hE, 4'hF:                info_d = info(2'd1, 3'd2);
                        default:                   info_d = info(2'd2, 3'd2);
                    endcase
                end
                4'h1: info_d = info(2'd2, 3'd2);
                4'h2: begin
                    case (hi)
                        4'h0, 4'h1:                info_d = info(2'd3, 3'd2);
                        4'h2, 4'h3, 4'hE, 4'hF:    info_d = info(2'd1, 3'd2);
                        4'h7, 4'h8, 4'h9:          info_d = info(2'd2, 3'd2);
                        default:                   info_d = info(2'd2, 3'd1);
                    endcase
                end
                4'h3: begin
                    case (hi)
                        4'h4, 4'h5, 4'h6:          info_d = info(2'd3, 3'd2);
                        4'h7, 4'h8, 4'h9, 4'hA,
                        4'hE, 4'hF:                info_d = info(2'd1, 3'd2);
                        default:                   info_d = info(2'd1, 3'd1);
                    endcase
                end
                4'h4: begin
                    case (hi)
                        4'h2, 4'h3, 4'h4, 4'h5,
                        4'h6, 4'h7, 4'h9:          info_d = info(2'd2, 3'd1);
                        4'hB:                      info_d = info(2'd3, 3'd2);
                        default:                   info_d = info(2'd1, 3'd1);
                    endcase
                end
                4'h5: begin
                    case (hi)
                        4'h7, 4'h8, 4'hB, 4'hD:    info_d = info(2'd3, 3'd2);
                        4'hA:                      info_d = info(2'd1, 3'd1);
                        default:                   info_d = info(2'd2, 3'd1);
                    endcase
                end
                // Columns 6..F address @Ri / Rn and share one row pattern.
                default: begin
                    case (hi)
                        4'h7:                      info_d = info(2'd2, 3'd1);
                        4'h8, 4'hA:                info_d = info(2'd2, 3'd2);
                        4'hB:                      info_d = info(2'd3, 3'd2);
                        4'hD:                      info_d = lo[3] ? info(2'd2, 3'd2) : info(2'd1, 3'd1);
                        default:                   info_d = info(2'd1, 3'd1);
                    endcase
                end
            endcase
        end
    end

    assign len_o    = info_d[LEN_W+CYC_W-1:CYC_W];
    assign cycles_o = info_d[CYC_W-1:0];

endmodule

// File: rtl/mc8051_instr_sequencer.sv
// Instruction fetch/sequencing controller: fetches opcode and operands, steps the execute counter,
// owns the PC and injects LCALL for interrupts at instruction boundaries.
module mc8051_instr_sequencer
    import mc8051_instr_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [7:0]  ILLEGAL_OP = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_code_req,
    output logic [15:0] o_code_addr,
    input  logic        i_code_ack,
    input  logic [7:0]  i_code_data,
    output logic [7:0]  o_instr_buffer,
    output logic [1:0]  o_multi_cycle_times,
    output logic [7:0]  o_operand1,
    output logic [7:0]  o_operand2,
    output logic        o_exec_valid,
    input  logic        i_exec_ready,
    input  logic        i_pc_load,
    input  logic [15:0] i_pc_new,
    output logic [15:0] o_pc,
    input  logic        i_int_req,
    input  logic [15:0] i_int_vector,
    output logic        o_int_ack,
    output logic        o_instr_done,
    output logic        o_illegal
);

    seq_state_e        state_q;
    logic [15:0]       pc_q;
    logic [7:0]        instr_q;
    logic [7:0]        opr1_q;
    logic [7:0]        opr2_q;
    logic [STEP_W-1:0] step_q;
    logic [LEN_W-1:0]  len_q;
    logic [CYC_W-1:0]  cycles_q;
    logic              exec_valid_q;
    logic              int_ack_q;
    logic              done_q;
    logic              illegal_q;

    logic [LEN_W-1:0]  rom_len;
    logic [CYC_W-1:0]  rom_cycles;
    logic [15:0]       pc_inc_d;
    logic [15:0]       pc_exec_d;
    logic              retire_d;

    mc8051_instr_len_rom #(
        .ILLEGAL_OP (ILLEGAL_OP)
    ) u_len_rom (
        .opcode_i (i_code_data),
        .len_o    (rom_len),
        .cycles_o (rom_cycles)
    );

    assign pc_inc_d  = pc_q + 16'd1;
    assign pc_exec_d = i_pc_load ? i_pc_new : pc_q;
    assign retire_d  = (state_q == ST_EXEC) && i_exec_ready
                       && ({1'b0, step_q} == (cycles_q - 3'd1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_FETCH_OP;
            pc_q         <= RESET_PC;
            instr_q      <= OP_NOP;
            opr1_q       <= 8'h00;
            opr2_q       <= 8'h00;
            step_q       <= '0;
            len_q        <= 2'd1;
            cycles_q     <= 3'd1;
            exec_valid_q <= 1'b0;
            int_ack_q    <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            int_ack_q <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_FETCH_OP: begin
                    if (i_code_ack) begin
                        instr_q   <= i_code_data;
                        opr1_q    <= 8'h00;
                        opr2_q    <= 8'h00;
                        len_q     <= rom_len;
                        cycles_q  <= rom_cycles;
                        pc_q      <= pc_inc_d;
                        step_q    <= '0;
                        illegal_q <= (i_code_data == ILLEGAL_OP);
                        if (rom_len == 2'd1) begin
                            state_q      <= ST_EXEC;
                            exec_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_FETCH_OPR1;
                        end
                    end
                end
                ST_FETCH_OPR1: begin
                    if (i_code_ack) begin
                        opr1_q <= i_code_data;
                        pc_q   <= pc_inc_d;
                        if (len_q == 2'd2) begin
                            state_q      <= ST_EXEC;
                            exec_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_FETCH_OPR2;
                        end
                    end
                end
                ST_FETCH_OPR2: begin
                    if (i_code_ack) begin
                        opr2_q       <= i_code_data;
                        pc_q         <= pc_inc_d;
                        state_q      <= ST_EXEC;
                        exec_valid_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (i_exec_ready) begin
                        pc_q <= pc_exec_d;
                        if (retire_d) begin
                            done_q <= 1'b1;
                            step_q <= '0;
                            // Interrupt: stay in EXEC with an LCALL; PC already holds the return address.
                            if (i_int_req) begin
                                instr_q   <= OP_LCALL;
                                opr1_q    <= i_int_vector[15:8];
                                opr2_q    <= i_int_vector[7:0];
                                cycles_q  <= 3'd2;
                                int_ack_q <= 1'b1;
                            end else begin
                                state_q      <= ST_FETCH_OP;
                                exec_valid_q <= 1'b0;
                            end
                        end else begin
                            step_q <= step_q + 2'd1;
                        end
                    end
                end
                default: state_q <= ST_FETCH_OP;
            endcase
        end
    end

    assign o_code_req          = (state_q != ST_EXEC);
    assign o_code_addr         = pc_q;
    assign o_pc                = pc_q;
    assign o_instr_buffer      = instr_q;
    assign o_operand1          = opr1_q;
    assign o_operand2          = opr2_q;
    assign o_multi_cycle_times = step_q;
    assign o_exec_valid        = exec_valid_q;
    assign o_int_ack           = int_ack_q;
    assign o_instr_done        = done_q;
    assign o_illegal           = illegal_q;

endmodule
